// File: rtl/sniffer_fifo_arbiter_pkg.sv
// Shared types and constants for the sniffer capture FIFO arbiter.
package sniffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } arb_state_t;

  localparam int unsigned CH_ID_W   = 4;
  localparam int unsigned SEQ_W     = 4;
  localparam int unsigned FIFO_W    = 64;
  localparam int unsigned PAYLOAD_W = FIFO_W - CH_ID_W - SEQ_W;

  // FIFO word layout: {channel id, sequence number, payload}
  function automatic logic [FIFO_W-1:0] pack_word(
    input logic [CH_ID_W-1:0]   id,
    input logic [SEQ_W-1:0]     seq,
    input logic [PAYLOAD_W-1:0] data
  );
    return {id, seq, data};
  endfunction

endpackage

// File: rtl/sniffer_fifo_arbiter_if.sv
// Channel-side valid/ready bus and FIFO write port of the capture arbiter.
interface sniffer_fifo_arbiter_if
  import sniffer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 56
);

  logic [NUM_CH-1:0]        ch_valid;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_ready;
  logic                     fifo_full;
  logic                     fifo_wr_en;
  logic [FIFO_W-1:0]        fifo_din;

  // master: the arbiter, which grants channels and writes the FIFO
  modport master (
    input  ch_valid, ch_data, fifo_full,
    output ch_ready, fifo_wr_en, fifo_din
  );

  // slave: the channels plus the FIFO attached to the arbiter
  modport slave (
    output ch_valid, ch_data, fifo_full,
    input  ch_ready, fifo_wr_en, fifo_din
  );

endinterface

// File: rtl/sniffer_fifo_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after ptr, with wrap-around.
module rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    // ptr itself is searched last so the previous winner has lowest priority
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(ptr) + k) % N;
      if (!gnt_vld && req[cand]) begin
        gnt_vld   = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/sniffer_fifo_arbiter.sv
// Round-robin arbiter sharing one 64-bit capture FIFO between NUM_CH sniffer channels.
module sniffer_fifo_arbiter
  import sniffer_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 56,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic                    busy,
  output logic [CNT_W-1:0]        words_written,
  output logic [CNT_W-1:0]        stall_cycles,
  sniffer_fifo_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t        state_q;
  logic              out_valid_q;
  logic [FIFO_W-1:0] out_data_q;
  logic [SEQ_W-1:0]  seq_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [CNT_W-1:0]  words_q;
  logic [CNT_W-1:0]  stall_q;

  logic [NUM_CH-1:0] gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              accept;
  logic              wr_en;
  logic              hs;
  logic              start_acc;
  logic [DATA_W-1:0] sel_data;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req     (bus.ch_valid & ch_en),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // Output slot can take a new word when empty or being written this cycle
  assign accept    = (state_q == RUN) && (!out_valid_q || wr_en);
  assign wr_en     = out_valid_q && !bus.fifo_full;
  assign hs        = accept && gnt_vld;
  assign start_acc = start && (state_q == IDLE);

  assign bus.ch_ready   = gnt & {NUM_CH{accept}};
  assign bus.fifo_wr_en = wr_en;
  assign bus.fifo_din   = out_data_q;
  assign busy           = (state_q != IDLE);
  assign words_written  = words_q;
  assign stall_cycles   = stall_q;

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sel_data = sel_data | (bus.ch_data[i*DATA_W +: DATA_W] & {DATA_W{gnt[i]}});
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      seq_q       <= '0;
      rr_ptr_q    <= IDX_W'(NUM_CH - 1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            seq_q   <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (hs) begin
        out_data_q  <= pack_word(CH_ID_W'(gnt_idx), seq_q, PAYLOAD_W'(sel_data));
        out_valid_q <= 1'b1;
        seq_q       <= seq_q + 1'b1;
        rr_ptr_q    <= gnt_idx;
      end else if (wr_en) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst || start_acc) begin
      words_q <= '0;
      stall_q <= '0;
    end else begin
      words_q <= words_q + CNT_W'(wr_en);
      if (out_valid_q && bus.fifo_full && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sniffer_fifo_arbiter.sv
// Directed self-checking bench for sniffer_fifo_arbiter.
module tb_sniffer_fifo_arbiter;
  import sniffer_pkg::*;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 56;
  localparam int unsigned CNT_W  = 32;

  logic              clk = 1'b0;
  logic              srst;
  logic              start;
  logic              stop;
  logic [NUM_CH-1:0] ch_en;
  logic              busy;
  logic [CNT_W-1:0]  words_written;
  logic [CNT_W-1:0]  stall_cycles;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  sniffer_fifo_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  sniffer_fifo_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .srst          (srst),
    .start         (start),
    .stop          (stop),
    .ch_en         (ch_en),
    .busy          (busy),
    .words_written (words_written),
    .stall_cycles  (stall_cycles),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] chan_word(input int unsigned i);
    return {48'h5A5A_0000_C0DE, 8'(8'hA0 + i)};
  endfunction

  function automatic logic [63:0] exp_din(input int unsigned id, input int unsigned seq);
    return {4'(id), 4'(seq), chan_word(id)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_and_start();
    srst = 1'b1; start = 1'b0; stop = 1'b0;
    bus.ch_valid = '0; bus.fifo_full = 1'b0; ch_en = 4'b1111;
    tick(); tick();
    srst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] hdr_tbl [8] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h04, 8'h15, 8'h26, 8'h37};

  initial begin
    for (int unsigned i = 0; i < NUM_CH; i++) bus.ch_data[i*DATA_W +: DATA_W] = chan_word(i);

    // reset values, with every channel requesting
    srst = 1'b1; start = 1'b0; stop = 1'b0; ch_en = 4'b1111;
    bus.ch_valid = 4'b1111; bus.fifo_full = 1'b0;
    tick(); tick();
    #1;
    check("rst_ready", bus.ch_ready, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_din",   bus.fifo_din, 0);
    check("rst_busy",  busy, 0);
    check("rst_words", words_written, 0);
    check("rst_stall", stall_cycles, 0);

    // full-rate round robin across all four channels
    reset_and_start();
    bus.ch_valid = 4'b1111;
    #1;
    check("rr_busy", busy, 1);
    for (int unsigned cyc = 0; cyc <= 9; cyc++) begin
      if (cyc < 8) check($sformatf("rr_ready%0d", cyc), bus.ch_ready, 64'(1) << (cyc % 4));
      if (cyc >= 1 && cyc <= 8) begin
        check($sformatf("rr_wr%0d", cyc), bus.fifo_wr_en, 1);
        check($sformatf("rr_hdr%0d", cyc), bus.fifo_din[63:56], hdr_tbl[cyc-1]);
      end
      if (cyc == 1) check("rr_din0", bus.fifo_din, exp_din(0, 0));
      if (cyc == 9) check("rr_words", words_written, 8);
      tick(); #1;
    end

    // backpressure holds the word for five cycles
    reset_and_start();
    bus.ch_valid = 4'b0001;
    #1;
    check("bp_ready0", bus.ch_ready, 4'b0001);
    tick();
    bus.ch_valid = 4'b1111; bus.fifo_full = 1'b1;
    #1;
    for (int unsigned i = 0; i < 5; i++) begin
      check($sformatf("bp_wr%0d", i), bus.fifo_wr_en, 0);
      check($sformatf("bp_ready%0d", i), bus.ch_ready, 0);
      check($sformatf("bp_din%0d", i), bus.fifo_din, exp_din(0, 0));
      tick(); #1;
    end
    bus.fifo_full = 1'b0;
    #1;
    check("bp_stall", stall_cycles, 5);
    check("bp_wr_release", bus.fifo_wr_en, 1);
    check("bp_din_release", bus.fifo_din, exp_din(0, 0));
    check("bp_ready_release", bus.ch_ready, 4'b0010);

    // masking: ch1/ch3 disabled, then ch2 disabled too
    reset_and_start();
    ch_en = 4'b0101; bus.ch_valid = 4'b1111;
    #1;
    for (int unsigned i = 0; i < 5; i++) begin
      check($sformatf("mask_ready%0d", i), bus.ch_ready, (i % 2 == 0) ? 4'b0001 : 4'b0100);
      tick(); #1;
    end
    ch_en = 4'b0001;
    #1;
    for (int unsigned i = 0; i < 2; i++) begin
      check($sformatf("mask0_ready%0d", i), bus.ch_ready, 4'b0001);
      tick(); #1;
    end

    // stop while the held word is blocked, start during drain ignored
    reset_and_start();
    ch_en = 4'b1111; bus.ch_valid = 4'b0001;
    #1;
    check("drain_ready0", bus.ch_ready, 4'b0001);
    tick();
    bus.ch_valid = 4'b1111; bus.fifo_full = 1'b1; stop = 1'b1;
    #1;
    check("drain_wr_blocked", bus.fifo_wr_en, 0);
    tick();
    stop = 1'b0; start = 1'b1;
    #1;
    check("drain_busy0", busy, 1);
    check("drain_ready1", bus.ch_ready, 0);
    tick();
    start = 1'b0;
    #1;
    check("drain_busy1", busy, 1);
    check("drain_ready2", bus.ch_ready, 0);
    check("drain_stall_kept", stall_cycles, 2);
    bus.fifo_full = 1'b0;
    #1;
    check("drain_wr", bus.fifo_wr_en, 1);
    check("drain_din", bus.fifo_din, exp_din(0, 0));
    check("drain_busy2", busy, 1);
    tick(); #1;
    check("drain_no_dup", bus.fifo_wr_en, 0);
    tick(); #1;
    check("drain_idle_busy", busy, 0);
    check("drain_idle_ready", bus.ch_ready, 0);
    check("drain_words", words_written, 1);

    // sequence wrap with a single channel
    reset_and_start();
    bus.ch_valid = 4'b0010;
    #1;
    for (int unsigned k = 0; k <= 17; k++) begin
      if (k <= 16) check($sformatf("seq_ready%0d", k), bus.ch_ready, 4'b0010);
      if (k >= 1) begin
        check($sformatf("seq_wr%0d", k), bus.fifo_wr_en, 1);
        check($sformatf("seq_din%0d", k), bus.fifo_din, exp_din(1, (k - 1) % 16));
      end
      tick(); #1;
    end
    bus.ch_valid = '0;

    // synchronous reset discards a held word
    reset_and_start();
    bus.ch_valid = 4'b0001;
    tick();
    bus.ch_valid = '0; bus.fifo_full = 1'b1;
    #1;
    check("srst_held_wr", bus.fifo_wr_en, 0);
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0; bus.fifo_full = 1'b0; bus.ch_valid = 4'b1111;
    #1;
    check("srst_wr", bus.fifo_wr_en, 0);
    check("srst_din", bus.fifo_din, 0);
    check("srst_busy", busy, 0);
    check("srst_ready", bus.ch_ready, 0);
    check("srst_words", words_written, 0);
    check("srst_stall", stall_cycles, 0);
    tick(); #1;
    check("srst_no_write", bus.fifo_wr_en, 0);
    check("srst_words_after", words_written, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
